// File: rtl/tlb_pipe.sv
// Registered dual-search TLB with per-entry valid bits, hardware Random replacement
// pointer bounded by Wired, and a one-entry-per-cycle invalidate walker (all / by ASID).
module tlb_pipe #(
    parameter int unsigned TLBNUM = 16,
    parameter int unsigned PFN_W  = 20,
    parameter int unsigned ASID_W = 8,
    localparam int unsigned IDXW  = $clog2(TLBNUM)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s0_req,
    input  logic [18:0]       s0_vpn2,
    input  logic              s0_odd_page,
    input  logic [ASID_W-1:0] s0_asid,
    output logic              s0_valid,
    output logic              s0_found,
    output logic              s0_multi,
    output logic [IDXW-1:0]   s0_index,
    output logic [PFN_W-1:0]  s0_pfn,
    output logic [2:0]        s0_c,
    output logic              s0_d,
    output logic              s0_v,
    input  logic              s1_req,
    input  logic [18:0]       s1_vpn2,
    input  logic              s1_odd_page,
    input  logic [ASID_W-1:0] s1_asid,
    output logic              s1_valid,
    output logic              s1_found,
    output logic              s1_multi,
    output logic [IDXW-1:0]   s1_index,
    output logic [PFN_W-1:0]  s1_pfn,
    output logic [2:0]        s1_c,
    output logic              s1_d,
    output logic              s1_v,
    input  logic              we,
    input  logic              w_random,
    input  logic [IDXW-1:0]   w_index,
    input  logic [18:0]       w_vpn2,
    input  logic [ASID_W-1:0] w_asid,
    input  logic              w_g,
    input  logic [PFN_W-1:0]  w_pfn0,
    input  logic [2:0]        w_c0,
    input  logic              w_d0,
    input  logic              w_v0,
    input  logic [PFN_W-1:0]  w_pfn1,
    input  logic [2:0]        w_c1,
    input  logic              w_d1,
    input  logic              w_v1,
    input  logic              r_req,
    input  logic [IDXW-1:0]   r_index,
    output logic              r_valid,
    output logic              r_e,
    output logic [18:0]       r_vpn2,
    output logic [ASID_W-1:0] r_asid,
    output logic              r_g,
    output logic [PFN_W-1:0]  r_pfn0,
    output logic [2:0]        r_c0,
    output logic              r_d0,
    output logic              r_v0,
    output logic [PFN_W-1:0]  r_pfn1,
    output logic [2:0]        r_c1,
    output logic              r_d1,
    output logic              r_v1,
    input  logic [IDXW-1:0]   wired,
    output logic [IDXW-1:0]   random_index,
    input  logic              inv_req,
    input  logic              inv_all,
    input  logic [ASID_W-1:0] inv_asid,
    output logic              inv_busy,
    output logic              inv_done
);
    localparam logic [IDXW-1:0] IdxMax = IDXW'(TLBNUM - 1);

    typedef enum logic [1:0] {StIdle, StWalk, StDone} inv_state_e;

    logic [TLBNUM-1:0] r_tlb_e;
    logic [18:0]       r_tlb_vpn2 [TLBNUM];
    logic [ASID_W-1:0] r_tlb_asid [TLBNUM];
    logic              r_tlb_g    [TLBNUM];
    logic [PFN_W-1:0]  r_tlb_pfn0 [TLBNUM];
    logic [PFN_W-1:0]  r_tlb_pfn1 [TLBNUM];
    logic [2:0]        r_tlb_c0   [TLBNUM];
    logic [2:0]        r_tlb_c1   [TLBNUM];
    logic              r_tlb_d0   [TLBNUM];
    logic              r_tlb_d1   [TLBNUM];
    logic              r_tlb_v0   [TLBNUM];
    logic              r_tlb_v1   [TLBNUM];

    logic [IDXW-1:0]   r_random;
    inv_state_e        r_state;
    logic [IDXW-1:0]   r_ptr;
    logic              r_inv_all;
    logic [ASID_W-1:0] r_inv_asid;

    logic [1:0]        w_s_req;
    logic [1:0]        w_s_odd;
    logic [18:0]       w_s_vpn2 [2];
    logic [ASID_W-1:0] w_s_asid [2];
    logic [IDXW-1:0]   w_tgt;
    logic              w_inv_hit;

    assign w_s_req     = {s1_req, s0_req};
    assign w_s_odd     = {s1_odd_page, s0_odd_page};
    assign w_s_vpn2[0] = s0_vpn2;
    assign w_s_vpn2[1] = s1_vpn2;
    assign w_s_asid[0] = s0_asid;
    assign w_s_asid[1] = s1_asid;

    for (genvar p = 0; p < 2; p++) begin : g_search
        logic [TLBNUM-1:0] w_match;
        logic [IDXW-1:0]   w_idx;
        logic              r_valid_p, r_found, r_multi, r_d, r_v;
        logic [IDXW-1:0]   r_index_p;
        logic [PFN_W-1:0]  r_pfn;
        logic [2:0]        r_c;

        // Descending scan so the lowest matching index is the one left in w_idx.
        always_comb begin
            w_match = '0;
            w_idx   = '0;
            for (int i = TLBNUM - 1; i >= 0; i--) begin
                w_match[i] = r_tlb_e[i] && (r_tlb_vpn2[i] == w_s_vpn2[p]) &&
                             ((r_tlb_asid[i] == w_s_asid[p]) || r_tlb_g[i]);
                if (w_match[i]) w_idx = IDXW'(i);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_valid_p <= 1'b0;
                r_found   <= 1'b0;
                r_multi   <= 1'b0;
                r_index_p <= '0;
                r_pfn     <= '0;
                r_c       <= '0;
                r_d       <= 1'b0;
                r_v       <= 1'b0;
            end else begin
                r_valid_p <= w_s_req[p];
                if (w_s_req[p]) begin
                    r_found   <= |w_match;
                    // Clearing the lowest set bit leaves something only on multiple hits.
                    r_multi   <= |(w_match & (w_match - TLBNUM'(1)));
                    r_index_p <= w_idx;
                    if (|w_match) begin
                        r_pfn <= w_s_odd[p] ? r_tlb_pfn1[w_idx] : r_tlb_pfn0[w_idx];
                        r_c   <= w_s_odd[p] ? r_tlb_c1[w_idx]   : r_tlb_c0[w_idx];
                        r_d   <= w_s_odd[p] ? r_tlb_d1[w_idx]   : r_tlb_d0[w_idx];
                        r_v   <= w_s_odd[p] ? r_tlb_v1[w_idx]   : r_tlb_v0[w_idx];
                    end else begin
                        r_pfn <= '0;
                        r_c   <= '0;
                        r_d   <= 1'b0;
                        r_v   <= 1'b0;
                    end
                end
            end
        end
    end

    assign s0_valid = g_search[0].r_valid_p;
    assign s0_found = g_search[0].r_found;
    assign s0_multi = g_search[0].r_multi;
    assign s0_index = g_search[0].r_index_p;
    assign s0_pfn   = g_search[0].r_pfn;
    assign s0_c     = g_search[0].r_c;
    assign s0_d     = g_search[0].r_d;
    assign s0_v     = g_search[0].r_v;
    assign s1_valid = g_search[1].r_valid_p;
    assign s1_found = g_search[1].r_found;
    assign s1_multi = g_search[1].r_multi;
    assign s1_index = g_search[1].r_index_p;
    assign s1_pfn   = g_search[1].r_pfn;
    assign s1_c     = g_search[1].r_c;
    assign s1_d     = g_search[1].r_d;
    assign s1_v     = g_search[1].r_v;

    assign w_tgt        = w_random ? r_random : w_index;
    assign w_inv_hit    = (r_state == StWalk) &&
                          (r_inv_all || (!r_tlb_g[r_ptr] && (r_tlb_asid[r_ptr] == r_inv_asid)));
    assign random_index = r_random;

    // The write's set is scheduled after the walker's clear so it wins on a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tlb_e <= '0;
        end else begin
            if (w_inv_hit) r_tlb_e[r_ptr] <= 1'b0;
            if (we)        r_tlb_e[w_tgt] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && we) begin
            r_tlb_vpn2[w_tgt] <= w_vpn2;
            r_tlb_asid[w_tgt] <= w_asid;
            r_tlb_g[w_tgt]    <= w_g;
            r_tlb_pfn0[w_tgt] <= w_pfn0;
            r_tlb_c0[w_tgt]   <= w_c0;
            r_tlb_d0[w_tgt]   <= w_d0;
            r_tlb_v0[w_tgt]   <= w_v0;
            r_tlb_pfn1[w_tgt] <= w_pfn1;
            r_tlb_c1[w_tgt]   <= w_c1;
            r_tlb_d1[w_tgt]   <= w_d1;
            r_tlb_v1[w_tgt]   <= w_v1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_e     <= 1'b0;
            r_vpn2  <= '0;
            r_asid  <= '0;
            r_g     <= 1'b0;
            r_pfn0  <= '0;
            r_c0    <= '0;
            r_d0    <= 1'b0;
            r_v0    <= 1'b0;
            r_pfn1  <= '0;
            r_c1    <= '0;
            r_d1    <= 1'b0;
            r_v1    <= 1'b0;
        end else begin
            r_valid <= r_req;
            if (r_req) begin
                r_e    <= r_tlb_e[r_index];
                r_vpn2 <= r_tlb_vpn2[r_index];
                r_asid <= r_tlb_asid[r_index];
                r_g    <= r_tlb_g[r_index];
                r_pfn0 <= r_tlb_pfn0[r_index];
                r_c0   <= r_tlb_c0[r_index];
                r_d0   <= r_tlb_d0[r_index];
                r_v0   <= r_tlb_v0[r_index];
                r_pfn1 <= r_tlb_pfn1[r_index];
                r_c1   <= r_tlb_c1[r_index];
                r_d1   <= r_tlb_d1[r_index];
                r_v1   <= r_tlb_v1[r_index];
            end
        end
    end

    // An IDXW-bit counter can never exceed TLBNUM-1, so only the Wired bound needs checking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_random <= IdxMax;
        end else if (r_random <= wired) begin
            r_random <= IdxMax;
        end else begin
            r_random <= r_random - IDXW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_ptr      <= '0;
            r_inv_all  <= 1'b0;
            r_inv_asid <= '0;
            inv_busy   <= 1'b0;
            inv_done   <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    inv_done <= 1'b0;
                    if (inv_req) begin
                        r_state    <= StWalk;
                        r_ptr      <= '0;
                        r_inv_all  <= inv_all;
                        r_inv_asid <= inv_asid;
                        inv_busy   <= 1'b1;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StWalk: begin
                    if (r_ptr == IdxMax) begin
                        r_state  <= StDone;
                        inv_busy <= 1'b0;
                        inv_done <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + IDXW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_pipe.sv
// Directed plus randomized bench for tlb_pipe, compared each cycle against an
// entry-list reference model of the TLB.
module tb_tlb_pipe;
    localparam int TLBNUM = 16;
    localparam int PFN_W  = 20;
    localparam int ASID_W = 8;

    logic clk = 1'b0;
    logic reset;
    logic s0_req, s0_odd_page, s1_req, s1_odd_page;
    logic [18:0] s0_vpn2, s1_vpn2;
    logic [7:0] s0_asid, s1_asid;
    logic s0_valid, s0_found, s0_multi, s0_d, s0_v, s1_valid, s1_found, s1_multi, s1_d, s1_v;
    logic [3:0] s0_index, s1_index;
    logic [19:0] s0_pfn, s1_pfn;
    logic [2:0] s0_c, s1_c;
    logic we, w_random, w_g, w_d0, w_v0, w_d1, w_v1;
    logic [3:0] w_index;
    logic [18:0] w_vpn2;
    logic [7:0] w_asid;
    logic [19:0] w_pfn0, w_pfn1;
    logic [2:0] w_c0, w_c1;
    logic r_req, r_valid, r_e, r_g, r_d0, r_v0, r_d1, r_v1;
    logic [3:0] r_index;
    logic [18:0] r_vpn2;
    logic [7:0] r_asid;
    logic [19:0] r_pfn0, r_pfn1;
    logic [2:0] r_c0, r_c1;
    logic [3:0] wired, random_index;
    logic inv_req, inv_all, inv_busy, inv_done;
    logic [7:0] inv_asid;

    int total = 0;
    int bad   = 0;

    // Reference model: plain entry arrays plus a few scalars.
    bit          m_e    [TLBNUM];
    logic [18:0] m_vpn2 [TLBNUM];
    logic [7:0]  m_asid [TLBNUM];
    bit          m_g    [TLBNUM];
    logic [19:0] m_pfn  [TLBNUM][2];
    logic [2:0]  m_c    [TLBNUM][2];
    bit          m_d    [TLBNUM][2];
    bit          m_v    [TLBNUM][2];
    int          m_rand;
    bit          m_walk;
    int          m_ptr;
    bit          m_iall;
    logic [7:0]  m_iasid;

    bit          e_sv [2], e_sf [2], e_sm [2], e_sd [2], e_svb [2];
    int          e_si [2];
    logic [19:0] e_sp [2];
    logic [2:0]  e_sc [2];
    bit          e_rv, e_re, e_rg, e_busy, e_done;
    logic [18:0] e_rvpn;
    logic [7:0]  e_rasid;
    logic [19:0] e_rpfn [2];
    logic [2:0]  e_rc [2];
    bit          e_rd [2], e_rvb [2];

    int seq [4] = '{14, 13, 12, 15};

    always #5 clk = ~clk;

    tlb_pipe #(.TLBNUM(TLBNUM), .PFN_W(PFN_W), .ASID_W(ASID_W)) dut (
        .clk(clk), .reset(reset),
        .s0_req(s0_req), .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
        .s0_valid(s0_valid), .s0_found(s0_found), .s0_multi(s0_multi), .s0_index(s0_index),
        .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_req(s1_req), .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_valid(s1_valid), .s1_found(s1_found), .s1_multi(s1_multi), .s1_index(s1_index),
        .s1_pfn(s1_pfn), .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
        .we(we), .w_random(w_random), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid),
        .w_g(w_g), .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_req(r_req), .r_index(r_index), .r_valid(r_valid), .r_e(r_e), .r_vpn2(r_vpn2),
        .r_asid(r_asid), .r_g(r_g), .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
        .wired(wired), .random_index(random_index),
        .inv_req(inv_req), .inv_all(inv_all), .inv_asid(inv_asid),
        .inv_busy(inv_busy), .inv_done(inv_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Predict the next-cycle outputs from current inputs, advance one clock, compare.
    task automatic tick();
        logic [18:0] sv [2];
        logic [7:0]  sa [2];
        bit          so [2], sr [2];
        int          hits, first, tgt, nrand, pg;
        sr[0] = s0_req; sv[0] = s0_vpn2; sa[0] = s0_asid; so[0] = s0_odd_page;
        sr[1] = s1_req; sv[1] = s1_vpn2; sa[1] = s1_asid; so[1] = s1_odd_page;
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) m_e[i] = 0;
            for (int p = 0; p < 2; p++) begin
                e_sv[p] = 0; e_sf[p] = 0; e_sm[p] = 0; e_si[p] = 0;
                e_sp[p] = '0; e_sc[p] = '0; e_sd[p] = 0; e_svb[p] = 0;
                e_rpfn[p] = '0; e_rc[p] = '0; e_rd[p] = 0; e_rvb[p] = 0;
            end
            e_rv = 0; e_re = 0; e_rvpn = '0; e_rasid = '0; e_rg = 0;
            m_rand = TLBNUM - 1; m_walk = 0; e_busy = 0; e_done = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                e_sv[p] = sr[p];
                if (sr[p]) begin
                    hits = 0; first = 0;
                    for (int i = 0; i < TLBNUM; i++)
                        if (m_e[i] && m_vpn2[i] == sv[p] && (m_asid[i] == sa[p] || m_g[i])) begin
                            if (hits == 0) first = i;
                            hits++;
                        end
                    pg = so[p] ? 1 : 0;
                    e_sf[p]  = hits > 0;
                    e_sm[p]  = hits > 1;
                    e_si[p]  = first;
                    e_sp[p]  = hits > 0 ? m_pfn[first][pg] : '0;
                    e_sc[p]  = hits > 0 ? m_c[first][pg] : '0;
                    e_sd[p]  = hits > 0 ? m_d[first][pg] : 0;
                    e_svb[p] = hits > 0 ? m_v[first][pg] : 0;
                end
            end
            e_rv = r_req;
            if (r_req) begin
                e_re = m_e[r_index]; e_rvpn = m_vpn2[r_index];
                e_rasid = m_asid[r_index]; e_rg = m_g[r_index];
                for (int k = 0; k < 2; k++) begin
                    e_rpfn[k] = m_pfn[r_index][k]; e_rc[k] = m_c[r_index][k];
                    e_rd[k] = m_d[r_index][k]; e_rvb[k] = m_v[r_index][k];
                end
            end
            tgt   = w_random ? m_rand : int'(w_index);
            nrand = (m_rand <= int'(wired)) ? TLBNUM - 1 : m_rand - 1;
            e_done = 0;
            if (m_walk) begin
                if (m_iall || (!m_g[m_ptr] && m_asid[m_ptr] == m_iasid)) m_e[m_ptr] = 0;
                if (m_ptr == TLBNUM - 1) begin
                    m_walk = 0; e_done = 1;
                end else m_ptr++;
            end else if (inv_req) begin
                m_walk = 1; m_ptr = 0; m_iall = inv_all; m_iasid = inv_asid;
            end
            e_busy = m_walk;
            if (we) begin
                m_e[tgt] = 1; m_vpn2[tgt] = w_vpn2; m_asid[tgt] = w_asid; m_g[tgt] = w_g;
                m_pfn[tgt][0] = w_pfn0; m_c[tgt][0] = w_c0; m_d[tgt][0] = w_d0; m_v[tgt][0] = w_v0;
                m_pfn[tgt][1] = w_pfn1; m_c[tgt][1] = w_c1; m_d[tgt][1] = w_d1; m_v[tgt][1] = w_v1;
            end
            m_rand = nrand;
        end
        @(posedge clk);
        #1;
        chk("s0_valid", 32'(s0_valid), 32'(e_sv[0]));
        chk("s0_found", 32'(s0_found), 32'(e_sf[0]));
        chk("s0_multi", 32'(s0_multi), 32'(e_sm[0]));
        chk("s0_index", 32'(s0_index), 32'(e_si[0]));
        chk("s0_pfn",   32'(s0_pfn),   32'(e_sp[0]));
        chk("s0_c",     32'(s0_c),     32'(e_sc[0]));
        chk("s0_d",     32'(s0_d),     32'(e_sd[0]));
        chk("s0_v",     32'(s0_v),     32'(e_svb[0]));
        chk("s1_valid", 32'(s1_valid), 32'(e_sv[1]));
        chk("s1_found", 32'(s1_found), 32'(e_sf[1]));
        chk("s1_multi", 32'(s1_multi), 32'(e_sm[1]));
        chk("s1_index", 32'(s1_index), 32'(e_si[1]));
        chk("s1_pfn",   32'(s1_pfn),   32'(e_sp[1]));
        chk("s1_c",     32'(s1_c),     32'(e_sc[1]));
        chk("s1_d",     32'(s1_d),     32'(e_sd[1]));
        chk("s1_v",     32'(s1_v),     32'(e_svb[1]));
        chk("r_valid",  32'(r_valid),  32'(e_rv));
        chk("r_e",      32'(r_e),      32'(e_re));
        chk("r_vpn2",   32'(r_vpn2),   32'(e_rvpn));
        chk("r_asid",   32'(r_asid),   32'(e_rasid));
        chk("r_g",      32'(r_g),      32'(e_rg));
        chk("r_pfn0",   32'(r_pfn0),   32'(e_rpfn[0]));
        chk("r_c0",     32'(r_c0),     32'(e_rc[0]));
        chk("r_d0",     32'(r_d0),     32'(e_rd[0]));
        chk("r_v0",     32'(r_v0),     32'(e_rvb[0]));
        chk("r_pfn1",   32'(r_pfn1),   32'(e_rpfn[1]));
        chk("r_c1",     32'(r_c1),     32'(e_rc[1]));
        chk("r_d1",     32'(r_d1),     32'(e_rd[1]));
        chk("r_v1",     32'(r_v1),     32'(e_rvb[1]));
        chk("random",   32'(random_index), 32'(m_rand));
        chk("inv_busy", 32'(inv_busy), 32'(e_busy));
        chk("inv_done", 32'(inv_done), 32'(e_done));
    endtask

    task automatic wr(input int idx, input logic [18:0] vpn, input logic [7:0] asid, input bit g,
                      input logic [19:0] p0, input logic [19:0] p1, input bit d1);
        we = 1; w_random = 0; w_index = 4'(idx); w_vpn2 = vpn; w_asid = asid; w_g = g;
        w_pfn0 = p0; w_c0 = 3'd2; w_d0 = 0; w_v0 = 1;
        w_pfn1 = p1; w_c1 = 3'd3; w_d1 = d1; w_v1 = 1;
        tick();
        we = 0;
    endtask

    task automatic search0(input logic [18:0] vpn, input logic [7:0] asid, input bit odd);
        s0_req = 1; s0_vpn2 = vpn; s0_asid = asid; s0_odd_page = odd;
        tick();
        s0_req = 0;
    endtask

    task automatic rd(input int idx);
        r_req = 1; r_index = 4'(idx);
        tick();
        r_req = 0;
    endtask

    initial begin
        reset = 1; s0_req = 0; s1_req = 0; s0_vpn2 = '0; s1_vpn2 = '0; s0_asid = '0;
        s1_asid = '0; s0_odd_page = 0; s1_odd_page = 0; we = 0; w_random = 0; w_index = '0;
        w_vpn2 = '0; w_asid = '0; w_g = 0; w_pfn0 = '0; w_pfn1 = '0; w_c0 = '0; w_c1 = '0;
        w_d0 = 0; w_d1 = 0; w_v0 = 0; w_v1 = 0; r_req = 0; r_index = '0; wired = '0;
        inv_req = 0; inv_all = 0; inv_asid = '0;
        #1;
        tick(); tick();
        reset = 0;
        // Give every entry known fields, then clear E again.
        for (int i = 0; i < TLBNUM; i++) wr(i, 19'h7FFF0 + 19'(i), 8'hEE, 0, 20'(i), 20'(i + 100), 0);
        reset = 1; tick(); reset = 0;
        chk("rst_random", 32'(random_index), 32'd15);

        search0(19'h12345, 8'h05, 0);
        chk("tp_miss_valid", 32'(s0_valid), 32'd1);
        chk("tp_miss_found", 32'(s0_found), 32'd0);
        chk("tp_miss_pfn", 32'(s0_pfn), 32'd0);

        wr(3, 19'h12345, 8'h05, 0, 20'hAAAAA, 20'hBBBBB, 1);
        search0(19'h12345, 8'h05, 1);
        chk("tp_hit_index", 32'(s0_index), 32'd3);
        chk("tp_hit_pfn", 32'(s0_pfn), 32'hBBBBB);
        chk("tp_hit_d", 32'(s0_d), 32'd1);
        search0(19'h12345, 8'h06, 1);
        chk("tp_asid_miss", 32'(s0_found), 32'd0);

        s0_req = 1; s0_vpn2 = 19'h00100; s0_asid = 8'h05; s0_odd_page = 0;
        wr(5, 19'h00100, 8'h05, 0, 20'h55555, 20'h66666, 0);
        s0_req = 0;
        chk("tp_prewrite_miss", 32'(s0_found), 32'd0);
        search0(19'h00100, 8'h05, 0);
        chk("tp_postwrite_pfn", 32'(s0_pfn), 32'h55555);

        wr(2, 19'h12345, 8'h05, 0, 20'h22222, 20'h22223, 0);
        wr(9, 19'h12345, 8'h05, 0, 20'h99999, 20'h99998, 0);
        search0(19'h12345, 8'h05, 0);
        chk("tp_multi_index", 32'(s0_index), 32'd2);
        chk("tp_multi", 32'(s0_multi), 32'd1);

        wired = 4'd12;
        for (int k = 0; k < 20 && m_rand != 15; k++) tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("tp_rand_seq", 32'(random_index), 32'(seq[k]));
        end
        for (int k = 0; k < 20 && m_rand != 13; k++) tick();
        we = 1; w_random = 1; w_vpn2 = 19'h13131; w_asid = 8'h13; w_g = 1; w_pfn0 = 20'h1300D;
        w_c0 = 3'd5; w_d0 = 1; w_v0 = 1; w_pfn1 = 20'h1300E; w_c1 = 3'd6; w_d1 = 0; w_v1 = 1;
        tick();
        we = 0; w_random = 0;
        rd(13);
        chk("tp_rand_r_e", 32'(r_e), 32'd1);
        chk("tp_rand_vpn2", 32'(r_vpn2), 32'h13131);
        wired = 4'd0;

        reset = 1; tick(); reset = 0;
        wr(1, 19'h00011, 8'h05, 0, 20'h1, 20'h2, 0);
        wr(4, 19'h00044, 8'h05, 1, 20'h3, 20'h4, 0);
        wr(7, 19'h00077, 8'h06, 0, 20'h5, 20'h6, 0);
        inv_req = 1; inv_all = 0; inv_asid = 8'h05;
        tick();
        inv_req = 0;
        chk("tp_busy_start", 32'(inv_busy), 32'd1);
        for (int k = 0; k < 15; k++) tick();
        chk("tp_busy_last", 32'(inv_busy), 32'd1);
        tick();
        chk("tp_done_pulse", 32'(inv_done), 32'd1);
        chk("tp_busy_end", 32'(inv_busy), 32'd0);
        tick();
        chk("tp_done_gone", 32'(inv_done), 32'd0);
        rd(1); chk("tp_inv_e1", 32'(r_e), 32'd0);
        rd(4); chk("tp_inv_e4", 32'(r_e), 32'd1);
        rd(7); chk("tp_inv_e7", 32'(r_e), 32'd1);
        inv_req = 1; inv_all = 1;
        tick();
        inv_req = 0; inv_all = 0;
        for (int k = 0; k < 17; k++) tick();
        search0(19'h00044, 8'h05, 0);
        chk("tp_invall_miss", 32'(s0_found), 32'd0);

        wr(0, 19'h00AAA, 8'h09, 1, 20'h7, 20'h8, 0);
        inv_req = 1; inv_all = 0; inv_asid = 8'h09;
        tick();
        inv_req = 0;
        for (int k = 0; k < 5; k++) tick();
        reset = 1; tick(); reset = 0;
        chk("tp_rst_busy", 32'(inv_busy), 32'd0);
        inv_req = 1;
        tick();
        inv_req = 0;
        chk("tp_reaccept", 32'(inv_busy), 32'd1);
        for (int k = 0; k < 17; k++) tick();
        rd(0); chk("tp_rst_e0", 32'(r_e), 32'd0);

        for (int n = 0; n < 500; n++) begin
            if (n % 60 == 0) wired = 4'($urandom_range(0, 15));
            reset = (n == 300);
            s0_req = 1'($urandom_range(0, 1)); s1_req = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: s0_vpn2 = 19'h12345;
                1: s0_vpn2 = 19'h00100;
                default: s0_vpn2 = 19'($urandom_range(0, 3));
            endcase
            s1_vpn2 = 19'($urandom_range(0, 3));
            s0_asid = 8'($urandom_range(4, 6)); s1_asid = 8'($urandom_range(4, 6));
            s0_odd_page = 1'($urandom_range(0, 1)); s1_odd_page = 1'($urandom_range(0, 1));
            we = ($urandom_range(0, 2) == 0); w_random = 1'($urandom_range(0, 1));
            w_index = 4'($urandom_range(0, 15)); w_vpn2 = 19'($urandom_range(0, 3));
            w_asid = 8'($urandom_range(4, 6)); w_g = ($urandom_range(0, 4) == 0);
            w_pfn0 = 20'($urandom); w_pfn1 = 20'($urandom);
            w_c0 = 3'($urandom); w_c1 = 3'($urandom);
            w_d0 = 1'($urandom); w_d1 = 1'($urandom); w_v0 = 1'($urandom); w_v1 = 1'($urandom);
            r_req = 1'($urandom_range(0, 1)); r_index = 4'($urandom_range(0, 15));
            inv_req = ($urandom_range(0, 25) == 0); inv_all = ($urandom_range(0, 3) == 0);
            inv_asid = 8'($urandom_range(4, 6));
            tick();
        end
        reset = 0; we = 0; inv_req = 0; s0_req = 0; s1_req = 0; r_req = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlb_pipe.md
# tlb_pipe

Parametrised, registered successor to the 16-entry dual-search MIPS-style TLB, sitting between the CP0/TLB-instruction logic and the fetch/memory address-translation paths. Adds per-entry valid (E) bits cleared by reset, 1-cycle registered search and read ports, multi-hit detection, a hardware Random replacement counter bounded by Wired, and a multi-cycle invalidate walker (all / by ASID).

## Interface
- TLBNUM, 16: entry count; power of 2, 4..64; IDXW = $clog2(TLBNUM)
- PFN_W, 20: PFN width
- ASID_W, 8: ASID width
- Reset: one clock; reset is synchronous and active-high
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- s0_req / s1_req  in  1  search request, port 0/1
- s0_vpn2, s1_vpn2  in  19  VPN2; s*_odd_page  in  1; s*_asid  in  ASID_W
- s0_valid, s1_valid  out  1  result valid (1 cycle after req)
- s*_found  out  1; s*_multi  out  1  >1 entry matched; s*_index  out  IDXW
- s*_pfn  out  PFN_W; s*_c  out  3; s*_d  out  1; s*_v  out  1
- we  in  1  write strobe; w_random  in  1  1: write at random_index, 0: at w_index
- w_index  in  IDXW; w_vpn2 19; w_asid ASID_W; w_g 1; w_pfn0/w_pfn1 PFN_W; w_c0/w_c1 3; w_d0/w_d1 1; w_v0/w_v1 1  (all in)
- r_req  in  1; r_index  in  IDXW
- r_valid  out  1; r_e, r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1  out  (field widths as write port)
- wired  in  IDXW  lower bound of random replacement
- random_index  out  IDXW  current Random value
- inv_req  in  1; inv_all  in  1; inv_asid  in  ASID_W
- inv_busy  out  1; inv_done  out  1  one-cycle pulse

## Operation
- Match(i): E[i] && vpn2 == tlb_vpn2[i] && (asid == tlb_asid[i] || tlb_g[i]).
- Search: on s*_req, match vector and selected-page fields (odd_page picks pfn1/c1/d1/v1) registered; found = |match; index = lowest matching index; multi = popcount(match) > 1; when !found, index/pfn/c/d/v = 0. s*_valid = registered s*_req. Outputs hold when no req.
- Write: on we, fields stored at target index and E[target] <= 1. Target = w_random ? random_index : w_index.
- Read: on r_req, all fields plus E at r_index registered; r_valid = registered r_req.
- Random: reset to TLBNUM-1; each cycle, if random_index <= wired or random_index > TLBNUM-1, load TLBNUM-1, else decrement. wired >= TLBNUM-1 pins it at TLBNUM-1.
- Invalidate FSM: IDLE -> WALK on inv_req (ignored when busy); latch inv_all/inv_asid; walk pointer 0..TLBNUM-1, one entry per cycle; clear E[ptr] if inv_all, or (!tlb_g[ptr] && tlb_asid[ptr] == latched asid). After ptr = TLBNUM-1: -> DONE (inv_done = 1 one cycle) -> IDLE. inv_busy = 1 in WALK.
- Write vs walker, same index same cycle: write wins (E = 1). Writes/searches/reads allowed during walk and see current state.

## Timing
- Reset values: all E = 0, s*_valid/found/multi/index/pfn/c/d/v = 0, r_valid and r_* = 0, random_index = TLBNUM-1, inv_busy = 0, inv_done = 0, FSM IDLE. Field arrays not reset.
- Search/read latency 1: request in cycle N, result valid cycle N+1; sample pre-write state (write in cycle N visible to requests from N+1).
- Invalidate: accept cycle N; entries cleared cycles N+1..N+TLBNUM; inv_done at N+TLBNUM+1; new inv_req accepted from N+TLBNUM+1.
- Reset mid-walk: walk aborted, IDLE, no inv_done; all E cleared anyway.

## Test plan
- Reset, then search vpn2=0x12345 asid=0x05 -> s0_valid=1 next cycle, found=0, index=0, pfn=0.
- Write index 3: vpn2=0x12345, asid=0x05, g=0, pfn0=0xAAAAA, v0=1, pfn1=0xBBBBB, d1=1; search odd_page=1 asid=0x05 -> found=1, index=3, pfn=0xBBBBB, d=1; asid=0x06 -> found=0; same-cycle write+search -> pre-write result.
- Same vpn2/asid written to indices 2 and 9 -> found=1, index=2, multi=1.
- wired=12, TLBNUM=16: random_index sequence 15,14,13,12,15,...; we with w_random when random_index=13 -> r_index=13 reads back fields with r_e=1.
- Entries 1 (asid 5, g=0), 4 (asid 5, g=1), 7 (asid 6) valid; inv_req asid=5 -> inv_busy 16 cycles, inv_done pulse; only E[1]=0; then inv_all -> all E=0, searches miss.
- Reset asserted 5 cycles into walk -> inv_busy=0 next cycle, no inv_done, all E=0; new inv_req accepted immediately after.
